// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_RD     = 4;

  // Widest entry the parity helper covers; narrower data is zero-extended by the caller.
  localparam int PAR_MAX_W  = 64;

  // Even parity bit: data plus this bit always holds an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for long-latency writebacks: set on issue, cleared by the write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             set_ok;

  assign set_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  // Set is applied after clear so a new issue wins over a same-cycle writeback.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[wr_addr] = 1'b0;
    if (set_ok) busy_nxt[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
    assign rd_busy[i] = busy[rd_addr[i*ADDR_W +: ADDR_W]];
  end

  assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-first bypass and busy scoreboard.
// Optional stored even parity per entry is enabled with `define REGFILE_PARITY_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     any_busy
`ifdef REGFILE_PARITY_EN
  ,
  output logic [NUM_RD-1:0]        rd_perr,
  input  logic                     perr_inject
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Interface contract: no handshake. wr_en is a single-cycle strobe that writes and retires
  // the register's outstanding op at the rising edge; sb_set is a single-cycle issue strobe;
  // reads are combinational every cycle and consumers stall while rd_busy is high.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [ADDR_W-1:0] ra     [NUM_RD];
  logic [NUM_RD-1:0] bypass;
  logic [NUM_RD-1:0] is_zero;

  // Bypass is suppressed under reset since the write it forwards is never committed.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign ra[i]      = rd_addr[i*ADDR_W +: ADDR_W];
    assign bypass[i]  = rst_n && wr_en && (wr_addr == ra[i]);
    assign is_zero[i] = (ZERO_REG != 0) && (ra[i] == '0);
    assign rd_data[i*DATA_W +: DATA_W] = is_zero[i] ? '0 :
                                         bypass[i]  ? wr_data : mem[ra[i]];
  end

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0] par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= '0;
    end else if (wr_ok) begin
      par[wr_addr] <= even_parity(PAR_MAX_W'(wr_data)) ^ perr_inject;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_perr
    assign rd_perr[i] = !is_zero[i] && !bypass[i] &&
                        (par[ra[i]] != even_parity(PAR_MAX_W'(mem[ra[i]])));
  end
`endif

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .any_busy (any_busy)
  );

endmodule
